// File: rtl/multiplex.sv
// multiplex: N-to-1 stream merger with round-robin arbitration.
// Each accepted word is tagged with its source index in the upper bits of
// m_dat, so a downstream demultiplexer can route it back.
// The output stage is a single register: one cycle latency, and full
// throughput because it can drain and reload in the same cycle.
module multiplex #(
    parameter int W  = 8,
    parameter int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      s_stb,
    input  logic [N*W-1:0]    s_dat,
    output logic [N-1:0]      s_rdy,
    input  logic              m_rdy,
    output logic              m_stb,
    output logic [IW+W-1:0]   m_dat
);

    // Output register and the last-grant pointer.
    logic              r_m_stb;
    logic [IW+W-1:0]   r_m_dat;
    logic [IW-1:0]     r_last;

    // Arbitration results.
    logic              w_found;
    logic [IW-1:0]     w_grant;
    logic [W-1:0]      w_pay;
    logic              w_space;
    logic              w_load;

    // Round-robin scan starting just after the last grant and wrapping back
    // to the last grant itself; the first requester encountered wins.
    always_comb begin
        logic [IW-1:0] w_idx;
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = IW'((int'(r_last) + k) % N);
            if (!w_found && s_stb[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // Select the payload of the granted slave.
    always_comb begin
        w_pay = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == IW'(i)) begin
                w_pay = s_dat[i*W +: W];
            end
        end
    end

    // The output register may take a new word when it is empty or when its
    // current word leaves this cycle; reset blocks all acceptance.
    always_comb begin
        w_space = !r_m_stb || m_rdy;
        w_load  = w_found && w_space && !rst;
    end

    // Accept strobe goes only to the granted slave, and only on a load.
    always_comb begin
        s_rdy = '0;
        for (int i = 0; i < N; i++) begin
            s_rdy[i] = w_load && (w_grant == IW'(i));
        end
    end

    // Output register and pointer update; the pointer moves only on a load,
    // so a slave withdrawing its request early leaves arbitration untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_stb <= 1'b0;
            r_m_dat <= '0;
            r_last  <= IW'(N - 1);
        end else if (w_load) begin
            r_m_stb <= 1'b1;
            r_m_dat <= {w_grant, w_pay};
            r_last  <= w_grant;
        end else if (r_m_stb && m_rdy) begin
            r_m_stb <= 1'b0;
        end
    end

    assign m_stb = r_m_stb;
    assign m_dat = r_m_dat;

endmodule

// File: tb/tb_multiplex.sv
// tb_multiplex: directed bench for multiplex (W=8, N=4) with a behavioural
// reference model compared every cycle and literal expectations per scenario.
module tb_multiplex;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      s_stb = '0;
    logic [N*W-1:0]    s_dat = '0;
    logic [N-1:0]      s_rdy;
    logic              m_rdy = 1'b1;
    logic              m_stb;
    logic [IW+W-1:0]   m_dat;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state.
    int              mlast = N - 1;
    bit              mstb  = 1'b0;
    logic [IW+W-1:0] mdat  = '0;

    multiplex #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_stb (s_stb),
        .s_dat (s_dat),
        .s_rdy (s_rdy),
        .m_rdy (m_rdy),
        .m_stb (m_stb),
        .m_dat (m_dat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Next requester in rotation after the model's last grant, or -1.
    function automatic int model_grant();
        for (int k = 1; k <= N; k++) begin
            if (s_stb[(mlast + k) % N]) return (mlast + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_rdy();
        int g;
        g = model_grant();
        if (g >= 0 && (!mstb || m_rdy) && !rst) return N'(1 << g);
        return '0;
    endfunction

    // Model advance on each rising edge (inputs are stable around the edge).
    always @(posedge clk) begin
        int g;
        g = model_grant();
        if (rst) begin
            mstb  = 1'b0;
            mdat  = '0;
            mlast = N - 1;
        end else if (g >= 0 && (!mstb || m_rdy)) begin
            mstb  = 1'b1;
            mdat  = {IW'(g), s_dat[g*W +: W]};
            mlast = g;
        end else if (mstb && m_rdy) begin
            mstb = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_s_rdy", 32'(s_rdy), 32'(model_rdy()));
            chk("model_m_stb", 32'(m_stb), 32'(mstb));
            if (mstb) chk("model_m_dat", 32'(m_dat), 32'(mdat));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dat(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        s_dat = {d3, d2, d1, d0};
    endtask

    initial begin
        // Reset with all slaves requesting.
        rst = 1'b1;
        s_stb = 4'b1111;
        m_rdy = 1'b1;
        set_dat(8'h10, 8'h11, 8'h12, 8'h13);
        cyc();
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_s_rdy", 32'(s_rdy), 32'h0);
            chk("rst_m_stb", 32'(m_stb), 32'h0);
            chk("rst_m_dat", 32'(m_dat), 32'h0);
            if (i == 0) cyc();
        end

        // Release: first grant is slave 0, then full-rate rotation.
        rst = 1'b0;
        #1;
        chk("first_grant", 32'(s_rdy), 32'h1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr_m_stb", 32'(m_stb), 32'h1);
            chk("rr_m_dat", 32'(m_dat), 32'({2'(i % 4), 8'(8'h10 + i % 4)}));
        end
        s_stb = 4'b0000;
        cyc();
        chk("rr_drain", 32'(m_stb), 32'h0);

        // Single stream from slave 2.
        s_stb = 4'b0100;
        set_dat(8'h00, 8'h00, 8'hA5, 8'h00);
        #1;
        chk("single_s_rdy", 32'(s_rdy), 32'h4);
        cyc();
        s_stb = 4'b0000;
        chk("single_m_stb", 32'(m_stb), 32'h1);
        chk("single_m_dat", 32'(m_dat), 32'h2A5);
        cyc();

        // Backpressure: slaves 1 and 3 request while downstream stalls.
        m_rdy = 1'b0;
        s_stb = 4'b1010;
        set_dat(8'h00, 8'h21, 8'h00, 8'h23);
        #1;
        chk("bp_first_rdy", 32'(s_rdy), 32'h8);
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_s_rdy", 32'(s_rdy), 32'h0);
            chk("bp_m_dat", 32'(m_dat), 32'h323);
            if (i < 4) cyc();
        end
        m_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(s_rdy), 32'h2);
        cyc();
        s_stb = 4'b0000;
        chk("bp_nobubble_stb", 32'(m_stb), 32'h1);
        chk("bp_nobubble_dat", 32'(m_dat), 32'h121);
        cyc();

        // Wrap and skip: park the pointer on 3, then only 2 and 3 request.
        s_stb = 4'b1000;
        set_dat(8'h00, 8'h00, 8'h32, 8'h33);
        cyc();
        s_stb = 4'b1100;
        #1;
        chk("wrap_first_rdy", 32'(s_rdy), 32'h4);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("wrap_m_dat", 32'(m_dat), (i % 2 == 0) ? 32'h232 : 32'h333);
        end
        s_stb = 4'b0000;
        cyc();

        // Reset while a word is held under backpressure.
        s_stb = 4'b0001;
        m_rdy = 1'b0;
        set_dat(8'h40, 8'h41, 8'h42, 8'h43);
        cyc();
        chk("mid_held_stb", 32'(m_stb), 32'h1);
        s_stb = 4'b1110;
        cyc();
        chk("mid_held_dat", 32'(m_dat), 32'h040);
        rst = 1'b1;
        cyc();
        chk("mid_rst_stb", 32'(m_stb), 32'h0);
        chk("mid_rst_dat", 32'(m_dat), 32'h0);
        rst = 1'b0;
        s_stb = 4'b1111;
        m_rdy = 1'b1;
        #1;
        chk("mid_restart_rdy", 32'(s_rdy), 32'h1);
        cyc();
        chk("mid_restart_dat", 32'(m_dat), 32'h040);

        // Mixed traffic with random stall and requests, checked by the model.
        for (int i = 0; i < 300; i++) begin
            s_stb = 4'($urandom_range(0, 15));
            m_rdy = 1'($urandom_range(0, 3) != 0);
            s_dat = $urandom();
            cyc();
        end
        s_stb = 4'b0000;
        m_rdy = 1'b1;
        cyc();
        cyc();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
